fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   Instruction-fetch front end of the unpipelined core; consumes the execute
//   stage's next-PC decision (nextPC/pcsrc) and owns the program counter.
//   Issues one request per instruction to instruction memory over a req/ack
//   handshake and holds the fetched word stable until the core retires it.
//   Detects a memory that never acknowledges and parks in a fault state.
// PARAMETERS
//   RESET_PC  32'h0000_0000  PC loaded on reset; bits [1:0] must be 0
//   TIMEOUT   255            max cycles in REQ without ack before FAULT (1..255)
// PORTS
//   i_clk         in   1   clock, all state on rising edge
//   i_rst_n       in   1   asynchronous active-low reset
//   i_nextPC      in   32  branch/jump target from execute stage
//   i_pcsrc       in   1   1 = take i_nextPC, 0 = sequential PC+4
//   i_advance     in   1   current instruction retired; sample nextPC/pcsrc
//   o_imem_addr   out  32  fetch address, word aligned (= o_pc)
//   o_imem_req    out  1   fetch request, held until ack
//   i_imem_ack    in   1   memory returns i_imem_data this cycle
//   i_imem_data   in   32  instruction word
//   o_instr       out  32  registered instruction, valid when o_valid
//   o_pc          out  32  address of o_instr / in-flight fetch
//   o_pcplus4     out  32  o_pc + 4, combinational, mod 2^32
//   o_valid       out  1   o_instr holds the word at o_pc
//   o_fault       out  1   fetch timeout, sticky until reset
// BEHAVIOUR
//   Reset (async, i_rst_n=0): state=START, o_pc=RESET_PC, o_instr=0,
//     o_valid=0, o_fault=0, timeout counter=0; o_imem_req=0 immediately.
//   States: START, REQ, HOLD, FAULT. o_imem_req=1 only in REQ (decoded).
//   START: unconditionally -> REQ on first edge after reset release.
//   REQ: addr/req stable; on i_imem_ack: o_instr<=i_imem_data, o_valid<=1,
//     cnt<=0, -> HOLD. Else cnt<=cnt+1; if cnt==TIMEOUT-1 -> FAULT.
//     Ack in same cycle as req rise accepted: o_valid high next cycle
//     (minimum fetch latency 1 cycle after req).
//   HOLD: o_instr/o_pc stable. On i_advance: o_valid<=0,
//     o_pc<= i_pcsrc ? {i_nextPC[31:2],2'b00} : o_pc+4, -> REQ.
//     Else remain.
//   FAULT: o_fault=1, o_valid=0, no requests; exit only by reset.
//   i_advance ignored outside HOLD; i_imem_ack ignored outside REQ.
//   i_advance and i_pcsrc sampled only in the same cycle; nextPC[1:0] dropped.
//   PC arithmetic 32-bit wraps: 32'hFFFF_FFFC + 4 -> 32'h0000_0000.
//   Reset mid-request: req drops same cycle, pending ack lost, restart at RESET_PC.
//   Counter width 8 bits; never counts outside REQ.
// TESTING
//   Reset release, ack 0 wait -> req at cycle 2, addr 0; ack with 0x2002_0005
//     -> o_valid=1, o_instr=0x2002_0005, o_pc=0 next cycle.
//   HOLD, advance, pcsrc=0 -> next addr 0x4; pcsrc=1, nextPC=0x0000_0103
//     -> addr 0x0000_0100.
//   o_pc=0xFFFF_FFFC, advance sequential -> addr 0x0, o_pcplus4 was 0x0.
//   Ack delayed 3 cycles -> req/addr stable 4 cycles, o_valid stays 0.
//   No ack for TIMEOUT=4 cycles -> o_fault=1, req=0; ack then ignored;
//     reset clears fault.
//   Assert i_rst_n=0 mid-REQ -> req=0 asynchronously, o_pc=RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues one req/ack fetch per
// instruction, holds the word until retired, and parks on a memory timeout.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_nextPC,
  input  logic        i_pcsrc,
  input  logic        i_advance,
  output logic [31:0] o_imem_addr,
  output logic        o_imem_req,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_data,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_pcplus4,
  output logic        o_valid,
  output logic        o_fault
);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] instr_r, instr_s;
  logic        valid_r, valid_s;
  logic        fault_r, fault_s;
  logic [7:0]  cnt_r, cnt_s;

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_START;
      pc_r    <= RESET_PC;
      instr_r <= 32'h0000_0000;
      valid_r <= 1'b0;
      fault_r <= 1'b0;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      instr_r <= instr_s;
      valid_r <= valid_s;
      fault_r <= fault_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    instr_s = instr_r;
    valid_s = valid_r;
    fault_s = fault_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_START: begin
        state_s = ST_REQ;
      end
      ST_REQ: begin
        if (i_imem_ack) begin
          instr_s = i_imem_data;
          valid_s = 1'b1;
          cnt_s   = 8'd0;
          state_s = ST_HOLD;
        end else if (cnt_r == CNT_LAST) begin
          // Timeout: clear the counter so it never carries into FAULT
          cnt_s   = 8'd0;
          valid_s = 1'b0;
          fault_s = 1'b1;
          state_s = ST_FAULT;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      ST_HOLD: begin
        if (i_advance) begin
          valid_s = 1'b0;
          pc_s    = i_pcsrc ? {i_nextPC[31:2], 2'b00} : (pc_r + 32'd4);
          state_s = ST_REQ;
        end else begin
          state_s = ST_HOLD;
        end
      end
      ST_FAULT: begin
        valid_s = 1'b0;
        fault_s = 1'b1;
        state_s = ST_FAULT;
      end
      default: begin
        state_s = ST_FAULT;
        valid_s = 1'b0;
        fault_s = 1'b1;
      end
    endcase
  end

  // Request is decoded from state so reset drops it without waiting for a clock
  assign o_imem_req  = (state_r == ST_REQ);
  assign o_imem_addr = pc_r;
  assign o_pc        = pc_r;
  assign o_pcplus4   = pc_r + 32'd4;
  assign o_instr     = instr_r;
  assign o_valid     = valid_r;
  assign o_fault     = fault_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, async-reset
// sequences, then randomized traffic against an abstract fetch model.
module tb_fetch_unit;

  localparam int unsigned TO = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] next_pc;
  logic        pcsrc;
  logic        advance;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pcplus4;
  logic        valid;
  logic        fault;

  int vectors = 0;
  int miscompares = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_nextPC(next_pc), .i_pcsrc(pcsrc),
    .i_advance(advance), .o_imem_addr(imem_addr), .o_imem_req(imem_req),
    .i_imem_ack(imem_ack), .i_imem_data(imem_data), .o_instr(instr),
    .o_pc(pc), .o_pcplus4(pcplus4), .o_valid(valid), .o_fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        adv;
    logic        src;
    logic [31:0] npc;
    logic        ack;
    logic [31:0] data;
    logic        e_req;
    logic [31:0] e_pc;
    logic        e_valid;
    logic [31:0] e_instr;
    logic        e_fault;
  } vec_t;

  vec_t tbl[20];

  task automatic check(input string name, input logic e_req, input logic [31:0] e_pc,
                       input logic e_valid, input logic [31:0] e_instr, input logic e_fault);
    logic [31:0] e_p4;
    e_p4 = e_pc + 32'd4;
    vectors++;
    if (imem_req !== e_req || pc !== e_pc || imem_addr !== e_pc || pcplus4 !== e_p4 ||
        valid !== e_valid || instr !== e_instr || fault !== e_fault) begin
      miscompares++;
      $display("FAIL %s: got req=%b pc=%h addr=%h p4=%h valid=%b instr=%h fault=%b; want req=%b pc=%h p4=%h valid=%b instr=%h fault=%b",
               name, imem_req, pc, imem_addr, pcplus4, valid, instr, fault,
               e_req, e_pc, e_p4, e_valid, e_instr, e_fault);
    end
  endtask

  task automatic drive(input logic a, input logic s, input logic [31:0] n,
                       input logic k, input logic [31:0] d);
    advance = a; pcsrc = s; next_pc = n; imem_ack = k; imem_data = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Abstract reference model
  int          m_phase;  // 0 just out of reset, 1 waiting for memory, 2 holding word, 3 faulted
  logic [31:0] m_pc, m_instr;
  int          m_waited;

  task automatic model_reset();
    m_phase = 0; m_pc = 32'h0; m_instr = 32'h0; m_waited = 0;
  endtask

  task automatic model_clock();
    if (m_phase == 0) begin
      m_phase = 1; m_waited = 0;
    end else if (m_phase == 1) begin
      if (imem_ack) begin
        m_instr = imem_data; m_phase = 2;
      end else begin
        m_waited = m_waited + 1;
        if (m_waited >= TO) m_phase = 3;
      end
    end else if (m_phase == 2) begin
      if (advance) begin
        m_pc = pcsrc ? (next_pc & 32'hFFFF_FFFC) : m_pc + 32'd4;
        m_phase = 1; m_waited = 0;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    tbl[0]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h2002_0005, 1'b0, 32'h0000_0000, 1'b1, 32'h2002_0005, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 32'h0000_0040, 1'b1, 32'h5555_5555, 1'b0, 32'h0000_0000, 1'b1, 32'h2002_0005, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 32'h0000_0040, 1'b0, 32'h0,         1'b1, 32'h0000_0004, 1'b0, 32'h2002_0005, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 32'h0000_0080, 1'b1, 32'h1111_1111, 1'b0, 32'h0000_0004, 1'b1, 32'h1111_1111, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 32'h0000_0103, 1'b0, 32'h0,         1'b1, 32'h0000_0100, 1'b0, 32'h1111_1111, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0000_0100, 1'b0, 32'h1111_1111, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0000_0100, 1'b0, 32'h1111_1111, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0000_0100, 1'b0, 32'h1111_1111, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0000_0100, 1'b1, 32'hDEAD_BEEF, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b0, 32'hDEAD_BEEF, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0123_4567, 1'b0, 32'hFFFF_FFFC, 1'b1, 32'h0123_4567, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 32'h0000_0200, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b0, 32'h0123_4567, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0A0A_0A0A, 1'b0, 32'h0000_0000, 1'b1, 32'h0A0A_0A0A, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0000_0004, 1'b0, 32'h0A0A_0A0A, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0000_0004, 1'b0, 32'h0A0A_0A0A, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0000_0004, 1'b0, 32'h0A0A_0A0A, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0000_0004, 1'b0, 32'h0A0A_0A0A, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0000_0004, 1'b0, 32'h0A0A_0A0A, 1'b1};
    tbl[19] = '{1'b1, 1'b1, 32'h0000_0300, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0000_0004, 1'b0, 32'h0A0A_0A0A, 1'b1};

    step();
    check("reset_state", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].adv, tbl[i].src, tbl[i].npc, tbl[i].ack, tbl[i].data);
      step();
      check($sformatf("table_%0d", i), tbl[i].e_req, tbl[i].e_pc, tbl[i].e_valid,
            tbl[i].e_instr, tbl[i].e_fault);
    end

    // Fault is sticky until reset, which clears it without a clock edge
    #2 rst_n = 1'b0;
    #1 check("fault_cleared_by_reset", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    rst_n = 1'b1;
    step();
    check("restart_req", 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hCAFE_0001);
    step();
    drive(1'b1, 1'b1, 32'h0000_0A0A, 1'b0, 32'h0);
    step();
    check("midreq_setup", 1'b1, 32'h0000_0A08, 1'b0, 32'hCAFE_0001, 1'b0);
    // Reset mid-request with an ack pending: request drops asynchronously
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hBAD0_BAD0);
    #3 rst_n = 1'b0;
    #1 check("midreq_async_reset", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step();
    check("midreq_ack_lost", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    rst_n = 1'b1;

    model_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 59) == 0 || (m_phase == 3 && $urandom_range(0, 3) == 0)) begin
        rst_n = 1'b0;
        #2;
        model_reset();
        check("rand_reset", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        rst_n = 1'b1;
      end
      drive($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, $urandom(),
            $urandom_range(0, 9) < 6, $urandom());
      model_clock();
      step();
      check($sformatf("rand_%0d", c), m_phase == 1, m_pc, m_phase == 2, m_instr, m_phase == 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
